// File: rtl/predicate_stage_pkg.sv
// rtl/predicate_stage_pkg.sv - shared defaults for the predicate stage
`ifndef NOP
`define NOP 32'h0000_0013
`endif

package predicate_stage_pkg;
  localparam int          PRED_W_DEF    = 4;
  localparam logic [3:0]  PRIV_BASE_DEF = 4'hC;
  localparam logic [31:0] NOP_INSTR_DEF = `NOP;
endpackage

// File: rtl/predicate_stage_skid_buf.sv
// rtl/predicate_stage_skid_buf.sv - two-entry skid buffer (main + skid), registered outputs
module skid_buf #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  output logic         ready_o,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  input  logic         ready_i
);
  logic         main_vld_q, main_vld_d;
  logic         skid_vld_q, skid_vld_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         pop;

  assign pop     = main_vld_q && ready_i;
  assign ready_o = !skid_vld_q;
  assign valid_o = main_vld_q;
  assign data_o  = main_q;

  always_comb begin
    main_vld_d = main_vld_q;
    skid_vld_d = skid_vld_q;
    main_d     = main_q;
    skid_d     = skid_q;
    if (flush_i) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (!main_vld_q || pop) begin
      // Skid entry is older than any incoming word, so it drains to main first.
      if (skid_vld_q) begin
        main_d     = skid_q;
        main_vld_d = 1'b1;
        skid_vld_d = push_i;
        if (push_i) skid_d = data_i;
      end else begin
        main_vld_d = push_i;
        if (push_i) main_d = data_i;
      end
    end else if (push_i) begin
      skid_vld_d = 1'b1;
      skid_d     = data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
    end else begin
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
    end
  end
endmodule

// File: rtl/predicate_stage.sv
// rtl/predicate_stage.sv - predicate evaluation, squash-to-NOP and squash counting
module predicate_stage
  import predicate_stage_pkg::*;
#(
  parameter int                 INSTR_W   = 32,
  parameter int                 PRED_W    = PRED_W_DEF,
  parameter int                 REG_W     = 32,
  parameter logic [PRED_W-1:0]  PRIV_BASE = PRIV_BASE_DEF,
  parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEF,
  parameter bit                 INVERT_EN = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [INSTR_W-1:0]        instr,
  output logic [PRED_W-1:0]         reg_addr,
  input  logic [REG_W-1:0]          reg_value,
  input  logic                      reg_busy,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [INSTR_W-PRED_W-1:0] instr_out,
  output logic                      privileged,
  output logic                      squashed,
  output logic [15:0]               squash_cnt,
  input  logic                      cnt_clr
);
  localparam int BODY_W = INSTR_W - PRED_W;

  logic              inv_bit;
  logic              pred;
  logic              accept;
  logic [BODY_W+1:0] entry;
  logic [BODY_W+1:0] out_entry;
  logic [15:0]       cnt_q, cnt_d;

  assign reg_addr = instr[INSTR_W-1 -: PRED_W];
  assign inv_bit  = INVERT_EN ? instr[BODY_W-1] : 1'b0;
  assign pred     = (reg_value == '0) ^ inv_bit;
  assign accept   = in_valid && in_ready && !reg_busy && !flush;
  assign entry    = {(reg_addr >= PRIV_BASE), !pred,
                     pred ? instr[BODY_W-1:0] : NOP_INSTR[BODY_W-1:0]};

  skid_buf #(.W(BODY_W + 2)) u_skid_buf (
    .clk_i   (clk),
    .rst_i   (rst),
    .flush_i (flush),
    .push_i  (accept),
    .data_i  (entry),
    .ready_o (in_ready),
    .valid_o (out_valid),
    .data_o  (out_entry),
    .ready_i (out_ready)
  );

  assign {privileged, squashed, instr_out} = out_entry;

  // Clear beats increment; the count sticks at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (accept && !pred && cnt_q != 16'hFFFF) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign squash_cnt = cnt_q;
endmodule

// File: tb/tb_predicate_stage.sv
// tb/tb_predicate_stage.sv - directed self-checking bench for predicate_stage
module tb_predicate_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [3:0]  reg_addr;
  logic [31:0] reg_value;
  logic        reg_busy;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [27:0] instr_out;
  logic        privileged;
  logic        squashed;
  logic [15:0] squash_cnt;
  logic        cnt_clr;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [27:0] NOP_BODY = 28'h000_0013;

  predicate_stage dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .instr      (instr),
    .reg_addr   (reg_addr),
    .reg_value  (reg_value),
    .reg_busy   (reg_busy),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .instr_out  (instr_out),
    .privileged (privileged),
    .squashed   (squashed),
    .squash_cnt (squash_cnt),
    .cnt_clr    (cnt_clr)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; instr = '0; reg_value = '0; reg_busy = 1'b0;
    flush = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
    step(); step();
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("rst_squashed", {31'd0, squashed}, 32'd0);
    check_eq("rst_priv", {31'd0, privileged}, 32'd0);
    check_eq("rst_instr_out", {4'd0, instr_out}, 32'd0);
    check_eq("rst_cnt", {16'd0, squash_cnt}, 32'd0);
    rst = 1'b0;
    step();

    // Predicate true, non-privileged
    in_valid = 1'b1; instr = 32'h3000_0123; reg_value = 32'd0; #1;
    check_eq("reg_addr", {28'd0, reg_addr}, 32'd3);
    step(); in_valid = 1'b0;
    check_eq("t1_valid", {31'd0, out_valid}, 32'd1);
    check_eq("t1_instr", {4'd0, instr_out}, 32'h0000_0123);
    check_eq("t1_squashed", {31'd0, squashed}, 32'd0);
    check_eq("t1_priv", {31'd0, privileged}, 32'd0);

    // Predicate false, privileged address
    in_valid = 1'b1; instr = 32'hD000_0055; reg_value = 32'd7;
    step(); in_valid = 1'b0;
    check_eq("t2_valid", {31'd0, out_valid}, 32'd1);
    check_eq("t2_instr", {4'd0, instr_out}, {4'd0, NOP_BODY});
    check_eq("t2_squashed", {31'd0, squashed}, 32'd1);
    check_eq("t2_priv", {31'd0, privileged}, 32'd1);
    check_eq("t2_cnt", {16'd0, squash_cnt}, 32'd1);
    step();
    check_eq("t2_drained", {31'd0, out_valid}, 32'd0);

    // Backpressure: two accepted, third refused, in-order release
    reg_value = 32'd0; out_ready = 1'b0; in_valid = 1'b1;
    instr = 32'h1000_0001; step();
    check_eq("bp_ready1", {31'd0, in_ready}, 32'd1);
    instr = 32'h2000_0002; step();
    check_eq("bp_ready2", {31'd0, in_ready}, 32'd0);
    instr = 32'h3000_0003; step();
    check_eq("bp_ready3", {31'd0, in_ready}, 32'd0);
    check_eq("bp_hold_valid", {31'd0, out_valid}, 32'd1);
    check_eq("bp_hold_instr", {4'd0, instr_out}, 32'h0000_0001);
    in_valid = 1'b0; out_ready = 1'b1; #1;
    check_eq("bp_first", {4'd0, instr_out}, 32'h0000_0001);
    step();
    check_eq("bp_second", {4'd0, instr_out}, 32'h0000_0002);
    check_eq("bp_ready_back", {31'd0, in_ready}, 32'd1);
    step();
    check_eq("bp_empty", {31'd0, out_valid}, 32'd0);
    in_valid = 1'b1; instr = 32'h3000_0003; step(); in_valid = 1'b0;
    check_eq("bp_third", {4'd0, instr_out}, 32'h0000_0003);
    step();

    // Busy register stalls
    reg_busy = 1'b1; in_valid = 1'b1; instr = 32'h4000_0004;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("busy_stall", {31'd0, out_valid}, 32'd0);
    end
    reg_busy = 1'b0; step(); in_valid = 1'b0;
    check_eq("busy_accept", {31'd0, out_valid}, 32'd1);
    check_eq("busy_instr", {4'd0, instr_out}, 32'h0000_0004);
    step();

    // Flush with both entries full
    out_ready = 1'b0; in_valid = 1'b1;
    instr = 32'h1000_0011; step();
    instr = 32'h2000_0022; step();
    flush = 1'b1; instr = 32'h5000_0005; step();
    flush = 1'b0; in_valid = 1'b0;
    check_eq("flush_valid", {31'd0, out_valid}, 32'd0);
    check_eq("flush_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1; step();
    check_eq("flush_dropped", {31'd0, out_valid}, 32'd0);

    // Drive squash_cnt from 1 up to FFFD, then saturate
    in_valid = 1'b1; instr = 32'hD000_0000; reg_value = 32'd1;
    for (int i = 0; i < 65532; i++) step();
    check_eq("sat_preset", {16'd0, squash_cnt}, 32'h0000_FFFD);
    step(); check_eq("sat_1", {16'd0, squash_cnt}, 32'h0000_FFFE);
    step(); check_eq("sat_2", {16'd0, squash_cnt}, 32'h0000_FFFF);
    step(); check_eq("sat_3", {16'd0, squash_cnt}, 32'h0000_FFFF);
    cnt_clr = 1'b1; step();
    check_eq("clr_wins", {16'd0, squash_cnt}, 32'd0);
    cnt_clr = 1'b0; step(); in_valid = 1'b0;
    check_eq("clr_then_inc", {16'd0, squash_cnt}, 32'd1);
    step();

    // Reset mid-transfer discards held entries
    out_ready = 1'b0; in_valid = 1'b1; reg_value = 32'd0; instr = 32'h1000_0077;
    step(); in_valid = 1'b0;
    rst = 1'b1; #1;
    check_eq("mrst_valid", {31'd0, out_valid}, 32'd0);
    check_eq("mrst_ready", {31'd0, in_ready}, 32'd1);
    check_eq("mrst_cnt", {16'd0, squash_cnt}, 32'd0);
    rst = 1'b0; out_ready = 1'b1; step();
    check_eq("mrst_no_out", {31'd0, out_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/predicate_stage.md
PREDICATE_STAGE -- requirements
Module: predicate_stage

Interface
REQ-001 SHALL have parameter INSTR_W, default 32, instruction width in bits.
REQ-002 SHALL have parameter PRED_W, default 4, predicate-register address width, taken from instr[INSTR_W-1 -: PRED_W].
REQ-003 SHALL have parameter REG_W, default 32, register value width.
REQ-004 SHALL have parameter PRIV_BASE, default 4'hC (width PRED_W); predicate addresses >= PRIV_BASE are privileged.
REQ-005 SHALL have parameter NOP_INSTR, default `NOP, of width INSTR_W; its low INSTR_W-PRED_W bits are substituted when an instruction is squashed.
REQ-006 SHALL have parameter INVERT_EN, default 0; when 1, instr bit INSTR_W-PRED_W-1 inverts the predicate sense.
REQ-007 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-008 Port: rst  input  1  asynchronous, active-high reset.
REQ-009 Port: in_valid  input  1  upstream instruction valid.
REQ-010 Port: in_ready  output  1  stage can accept an instruction.
REQ-011 Port: instr  input  INSTR_W  incoming instruction.
REQ-012 Port: reg_addr  output  PRED_W  predicate-register read address, combinationally equal to instr[INSTR_W-1 -: PRED_W].
REQ-013 Port: reg_value  input  REG_W  predicate-register read data, same cycle.
REQ-014 Port: reg_busy  input  1  scoreboard reports reg_addr as having a pending write.
REQ-015 Port: flush  input  1  discard all held and incoming instructions.
REQ-016 Port: out_valid  output  1  downstream instruction valid.
REQ-017 Port: out_ready  input  1  downstream accepts.
REQ-018 Port: instr_out  output  INSTR_W-PRED_W  instruction or NOP body.
REQ-019 Port: privileged  output  1  predicate address of instr_out >= PRIV_BASE.
REQ-020 Port: squashed  output  1  instr_out is a substituted NOP.
REQ-021 Port: squash_cnt  output  16  saturating count of squashed instructions.
REQ-022 Port: cnt_clr  input  1  synchronous clear of squash_cnt.

Function
REQ-023 Predicate true SHALL mean reg_value == 0, XOR the invert bit when INVERT_EN=1; the invert bit passes through unchanged in instr_out.
REQ-024 An accept SHALL occur when in_valid && in_ready && !reg_busy && !flush; a busy register SHALL stall without accepting.
REQ-025 Accepted data SHALL be pred ? instr[INSTR_W-PRED_W-1:0] : NOP_INSTR[INSTR_W-PRED_W-1:0], with squashed=!pred and privileged evaluated at accept time.
REQ-026 Latency SHALL be 1 cycle from accept to out_valid, all outputs registered.
REQ-027 Buffering SHALL be a 2-entry skid buffer (main plus skid): in_ready = !skid_valid, registered; full throughput when out_ready stays high.
REQ-028 When out_ready is low and main holds data, an accept SHALL fill skid; on a later out_ready, skid moves to main in order.
REQ-029 The output SHALL hold stable while out_valid && !out_ready.
REQ-030 flush SHALL clear both entries at the next edge (out_valid=0, in_ready=1); same-cycle input is dropped; flush wins over accept.
REQ-031 squash_cnt SHALL increment once per accepted squashed instruction, saturate at 16'hFFFF, and cnt_clr SHALL take priority over an increment in the same cycle.

Reset
REQ-032 rst SHALL asynchronously force out_valid=0, in_ready=1, squashed=0, privileged=0, instr_out=0, squash_cnt=0, with both entries empty.
REQ-033 rst asserted mid-transfer SHALL discard held entries; no output SHALL appear before the first accept after release.

Structure
REQ-034 PRED_W, PRIV_BASE and the NOP_INSTR default SHALL come from the shared package alongside `NOP.
REQ-035 The skid buffer SHALL be one sub-module, skid_buf, parametrised by width; predicate evaluation stays in predicate_stage.

Verification
REQ-036 instr=32'h3000_0123, reg_value=0, out_ready=1 -> next cycle out_valid=1, instr_out=28'h000_0123, squashed=0, privileged=0.
REQ-037 instr=32'hD000_0055, reg_value=7 -> instr_out=NOP body, squashed=1, privileged=1, squash_cnt increments by 1.
REQ-038 out_ready=0 with 3 back-to-back valid inputs -> two accepted, in_ready=0 on the third; release gives in-order output with no loss.
REQ-039 reg_busy=1 for 3 cycles with in_valid=1 -> no accept and no out_valid; accept on the first cycle after reg_busy drops.
REQ-040 Both entries full, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, input dropped.
REQ-041 squash_cnt preset near 16'hFFFF, then 3 squashes -> holds 16'hFFFF; cnt_clr concurrent with a squash -> 0.
